and_compare_sequencer: RTL and testbench

AND_COMPARE_SEQUENCER -- requirements
Module: and_compare_sequencer

---
 rtl/and_cmp_pkg.sv | 20 ++
 rtl/and_compare_sequencer.sv | 119 +++++++++++
 tb/tb_and_compare_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/and_cmp_pkg.sv
// Shared types and sizes for the AND-gate compare sequencer.
package and_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  localparam int NUM_VEC = 8;
  localparam int ERR_W   = 4;
  localparam int VEC_W   = 3;

  // Golden response of a 3-input AND gate for one stimulus vector.
  function automatic logic expectedAnd(input logic [VEC_W-1:0] vec);
    return &vec;
  endfunction

endpackage

// File: rtl/and_compare_sequencer.sv
// Walks {a,b,c} through all eight input combinations of an and_compare DUT and
// scores both of its outputs against the expected AND result.
module and_compare_sequencer
  import and_cmp_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             out1,
  input  logic             out2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_err_vec,
  output logic             first_err_valid
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e             state_q;
  logic [VEC_W-1:0]   vec_q;
  logic [VEC_W-1:0]   abc_q;
  logic [3:0]         settleCnt_q;
  logic [ERR_W-1:0]   errCount_q;
  logic [ERR_W-1:0]   errCount_d;
  logic [VEC_W-1:0]   firstErrVec_q;
  logic               firstErrValid_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               expected;
  logic               vecFail;
  logic               lastVec;

  // Score the vector currently on the DUT inputs; only consumed in CHECK.
  always_comb begin
    expected   = expectedAnd(abc_q);
    vecFail    = (out1 != expected) || (out2 != expected);
    errCount_d = errCount_q + ERR_W'(vecFail);
    lastVec    = (vec_q == VEC_W'(NUM_VEC - 1));
  end

  // Sequencer FSM; every status output is a flop so nothing leaks from start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      vec_q           <= '0;
      abc_q           <= '0;
      settleCnt_q     <= '0;
      errCount_q      <= '0;
      firstErrVec_q   <= '0;
      firstErrValid_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            vec_q           <= '0;
            abc_q           <= '0;
            settleCnt_q     <= SETTLE_LOAD;
            errCount_q      <= '0;
            firstErrVec_q   <= '0;
            firstErrValid_q <= 1'b0;
            busy_q          <= 1'b1;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            state_q         <= SETTLE;
          end
        end
        SETTLE: begin
          if (settleCnt_q == '0) begin
            state_q <= CHECK;
          end else begin
            settleCnt_q <= settleCnt_q - 4'd1;
          end
        end
        CHECK: begin
          errCount_q <= errCount_d;
          if (vecFail && !firstErrValid_q) begin
            firstErrVec_q   <= abc_q;
            firstErrValid_q <= 1'b1;
          end
          // The last vector stays on the DUT inputs rather than wrapping to 000.
          if (lastVec) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (errCount_d == '0);
            state_q <= DONE;
          end else begin
            vec_q       <= vec_q + VEC_W'(1);
            abc_q       <= vec_q + VEC_W'(1);
            settleCnt_q <= SETTLE_LOAD;
            state_q     <= SETTLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign {a, b, c}       = abc_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = errCount_q;
  assign first_err_vec   = firstErrVec_q;
  assign first_err_valid = firstErrValid_q;

endmodule

// File: tb/tb_and_compare_sequencer.sv
// Directed bench: two sequencers (1 and 3 settle cycles) driving a behavioural
// and_compare model with selectable faults on its outputs.
module tb_and_compare_sequencer;

  logic       clk;
  logic       rst;
  logic       start1;
  logic       start3;
  int         faultMode;
  int         sel;
  int         checkCount;
  int         passCount;
  int         doneCycle;

  logic       a1, b1, c1, busy1, done1, pass1, fevv1, out1A, out2A;
  logic [3:0] err1;
  logic [2:0] fev1;
  logic       a3, b3, c3, busy3, done3, pass3, fevv3, out1B, out2B;
  logic [3:0] err3;
  logic [2:0] fev3;

  logic [2:0] selAbc;
  logic       selBusy;
  logic       selDone;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural and_compare: faultMode 1 sticks out2 low, 2 inverts out1.
  assign out1A = (faultMode == 2) ? ~(a1 & b1 & c1) : (a1 & b1 & c1);
  assign out2A = (faultMode == 1) ? 1'b0 : (a1 & b1 & c1);
  assign out1B = (faultMode == 2) ? ~(a3 & b3 & c3) : (a3 & b3 & c3);
  assign out2B = (faultMode == 1) ? 1'b0 : (a3 & b3 & c3);

  assign selAbc  = (sel == 3) ? {a3, b3, c3} : {a1, b1, c1};
  assign selBusy = (sel == 3) ? busy3 : busy1;
  assign selDone = (sel == 3) ? done3 : done1;

  and_compare_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .c(c1), .out1(out1A), .out2(out2A),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_vec(fev1), .first_err_valid(fevv1)
  );

  and_compare_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .a(a3), .b(b3), .c(c3), .out1(out1B), .out2(out2B),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_vec(fev3), .first_err_valid(fevv3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setStart(input logic v);
    if (sel == 3) start3 = v;
    else start1 = v;
  endtask

  // Pulse start on the selected sequencer, optionally re-pulse it at cycle
  // restartAt, check the vector walk every cycle and report when done rises.
  task automatic applyStimulus(input int which, input int restartAt, output int cyc);
    int perVec;
    int expVec;
    sel    = which;
    perVec = (which == 3) ? 4 : 2;
    cyc    = -1;
    @(negedge clk);
    setStart(1'b1);
    @(posedge clk);
    #1;
    setStart(1'b0);
    checkOutput("abcAtStart", 32'(selAbc), 32'd0);
    checkOutput("busyAtStart", 32'(selBusy), 32'd1);
    for (int k = 1; k <= 200 && cyc < 0; k++) begin
      if (k == restartAt) setStart(1'b1);
      @(posedge clk);
      #1;
      setStart(1'b0);
      expVec = (k / perVec > 7) ? 7 : k / perVec;
      checkOutput("abcWalk", 32'(selAbc), 32'(expVec));
      if (selDone) cyc = k;
    end
    checkOutput("busyAtDone", 32'(selBusy), 32'd0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    faultMode  = 0;
    sel        = 1;
    rst        = 1'b1;
    start1     = 1'b0;
    start3     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstAbc", 32'({a1, b1, c1}), 32'd0);
    checkOutput("rstBusy", 32'(busy1), 32'd0);
    checkOutput("rstDone", 32'(done1), 32'd0);
    checkOutput("rstPass", 32'(pass1), 32'd0);
    checkOutput("rstErr", 32'(err1), 32'd0);
    checkOutput("rstFev", 32'(fev1), 32'd0);
    checkOutput("rstFevv", 32'(fevv1), 32'd0);
    rst = 1'b0;

    $display("[TB] clean DUT, one settle cycle");
    applyStimulus(1, -1, doneCycle);
    checkOutput("cleanDoneCycle", 32'(doneCycle), 32'd16);
    checkOutput("cleanPass", 32'(pass1), 32'd1);
    checkOutput("cleanErr", 32'(err1), 32'd0);
    checkOutput("cleanFevv", 32'(fevv1), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("holdDone", 32'(done1), 32'd1);
    checkOutput("holdPass", 32'(pass1), 32'd1);
    checkOutput("holdAbc", 32'({a1, b1, c1}), 32'd7);

    $display("[TB] out2 stuck low");
    faultMode = 1;
    applyStimulus(1, -1, doneCycle);
    checkOutput("stuckDoneCycle", 32'(doneCycle), 32'd16);
    checkOutput("stuckErr", 32'(err1), 32'd1);
    checkOutput("stuckFev", 32'(fev1), 32'd7);
    checkOutput("stuckFevv", 32'(fevv1), 32'd1);
    checkOutput("stuckPass", 32'(pass1), 32'd0);

    $display("[TB] out1 inverted");
    faultMode = 2;
    applyStimulus(1, -1, doneCycle);
    checkOutput("invErr", 32'(err1), 32'd8);
    checkOutput("invFev", 32'(fev1), 32'd0);
    checkOutput("invFevv", 32'(fevv1), 32'd1);
    checkOutput("invPass", 32'(pass1), 32'd0);

    $display("[TB] start re-pulsed during vector 2");
    faultMode = 0;
    applyStimulus(1, 5, doneCycle);
    checkOutput("repulseDoneCycle", 32'(doneCycle), 32'd16);
    checkOutput("repulsePass", 32'(pass1), 32'd1);
    checkOutput("repulseErr", 32'(err1), 32'd0);

    $display("[TB] reset during settle of vector 3");
    faultMode = 2;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midRunAbc", 32'({a1, b1, c1}), 32'd3);
    checkOutput("midRunErr", 32'(err1), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midRstAbc", 32'({a1, b1, c1}), 32'd0);
    checkOutput("midRstBusy", 32'(busy1), 32'd0);
    checkOutput("midRstDone", 32'(done1), 32'd0);
    checkOutput("midRstErr", 32'(err1), 32'd0);
    checkOutput("midRstFevv", 32'(fevv1), 32'd0);
    checkOutput("midRstFev", 32'(fev1), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleStaysIdle", 32'(busy1), 32'd0);
    faultMode = 0;
    applyStimulus(1, -1, doneCycle);
    checkOutput("afterRstDoneCycle", 32'(doneCycle), 32'd16);
    checkOutput("afterRstPass", 32'(pass1), 32'd1);

    $display("[TB] three settle cycles");
    applyStimulus(3, -1, doneCycle);
    checkOutput("slowDoneCycle", 32'(doneCycle), 32'd32);
    checkOutput("slowPass", 32'(pass3), 32'd1);
    checkOutput("slowErr", 32'(err3), 32'd0);
    checkOutput("slowFevv", 32'(fevv3), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
